// File: rtl/cic_channel_arbiter.sv
// Round-robin merge of NumChannels decimator output streams onto one tagged,
// fully registered output stream with one-sample-per-clock throughput.
module cic_channel_arbiter #(
    parameter int NumChannels    = 4,
    parameter int DataLengthBits = 36,
    parameter int ChannelIdBits  = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NumChannels-1:0]                 channel_enable,
    input  logic [NumChannels*DataLengthBits-1:0]  in,
    input  logic [NumChannels-1:0]                 in_valid,
    output logic [NumChannels-1:0]                 in_ready,
    output logic [DataLengthBits-1:0]              out,
    output logic [ChannelIdBits-1:0]               out_channel,
    output logic                                   out_valid,
    input  logic                                   out_ready
);

    logic [DataLengthBits-1:0] r_out;
    logic [ChannelIdBits-1:0]  r_out_channel;
    logic                      r_out_valid;
    logic [ChannelIdBits-1:0]  r_last_grant;

    logic [NumChannels-1:0]    w_req;
    logic                      w_load;
    logic                      w_grant_valid;
    logic [ChannelIdBits-1:0]  w_grant_idx;
    logic [DataLengthBits-1:0] w_in_data [NumChannels];

    // Channel index reached k steps after base, wrapping modulo NumChannels.
    function automatic logic [ChannelIdBits-1:0] f_wrap(input int base, input int k);
        int s;
        s = base + k;
        if (s >= NumChannels) s = s - NumChannels;
        return s[ChannelIdBits-1:0];
    endfunction

    assign w_req  = in_valid & channel_enable;
    assign w_load = !r_out_valid || out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NumChannels; gi++) begin : g_chan
            assign w_in_data[gi] = in[gi*DataLengthBits +: DataLengthBits];
            assign in_ready[gi]  = rst && w_load && w_grant_valid &&
                                   (w_grant_idx == ChannelIdBits'(gi));
        end
    endgenerate

    // Search from farthest to nearest so the nearest requester after the
    // last grant is the one left standing.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int k = NumChannels; k >= 1; k--) begin
            if (w_req[f_wrap(int'(r_last_grant), k)]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = f_wrap(int'(r_last_grant), k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out         <= '0;
            r_out_channel <= '0;
            r_out_valid   <= 1'b0;
            r_last_grant  <= ChannelIdBits'(NumChannels - 1);
        end else if (w_load) begin
            if (w_grant_valid) begin
                r_out         <= w_in_data[w_grant_idx];
                r_out_channel <= w_grant_idx;
                r_out_valid   <= 1'b1;
                r_last_grant  <= w_grant_idx;
            end else begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    assign out         = r_out;
    assign out_channel = r_out_channel;
    assign out_valid   = r_out_valid;

endmodule

// File: tb/tb_cic_channel_arbiter.sv
// Directed and randomized checks of cic_channel_arbiter against a cycle-level
// behavioural model of the round-robin merge.
module tb_cic_channel_arbiter;

    localparam int N  = 4;
    localparam int W  = 36;
    localparam int CB = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    channel_enable;
    logic [N*W-1:0]  in_bus;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out;
    logic [CB-1:0]   out_channel;
    logic            out_valid;
    logic            out_ready;

    logic [W-1:0]    data [N];

    // Model state
    logic            m_valid;
    logic [W-1:0]    m_out;
    int              m_ch;
    int              m_last;
    int              grant_count [N];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cic_channel_arbiter #(.NumChannels(N), .DataLengthBits(W), .ChannelIdBits(CB)) dut (
        .clk            (clk),
        .rst            (rst),
        .channel_enable (channel_enable),
        .in             (in_bus),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out            (out),
        .out_channel    (out_channel),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: compare DUT to model, then advance the model across the edge.
    task automatic step(input string tag);
        int           g;
        logic         load;
        logic [N-1:0] exp_ready;
        logic         rst_s;
        for (int i = 0; i < N; i++) in_bus[i*W +: W] = data[i];
        #1;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (g < 0 && in_valid[c] && channel_enable[c]) g = c;
        end
        load      = !m_valid || out_ready;
        exp_ready = (rst && load && g >= 0) ? N'(1 << g) : '0;
        rst_s     = rst;
        $display("%s: rst=%0b en=%b v=%b ordy=%0b | in_ready=%b out_valid=%0b ch=%0d out=%0h",
                 tag, rst, channel_enable, in_valid, out_ready, in_ready, out_valid, out_channel, out);
        chk({tag, ".out_valid"},   64'(out_valid),   64'(m_valid));
        chk({tag, ".out"},         64'(out),         64'(m_out));
        chk({tag, ".out_channel"}, 64'(out_channel), 64'(m_ch));
        chk({tag, ".in_ready"},    64'(in_ready),    64'(exp_ready));
        @(posedge clk);
        if (!rst_s) begin
            m_valid = 1'b0; m_out = '0; m_ch = 0; m_last = N - 1;
        end else if (load) begin
            if (g >= 0) begin
                m_out = data[g]; m_ch = g; m_valid = 1'b1; m_last = g;
                grant_count[g]++;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        m_valid = 1'b0; m_out = '0; m_ch = 0; m_last = N - 1;
        for (int i = 0; i < N; i++) begin
            data[i] = W'(100 + i);
            grant_count[i] = 0;
        end
        rst = 1'b0; channel_enable = '1; in_valid = '1; out_ready = 1'b1;

        for (int c = 0; c < 100; c++) step("reset_hold");

        rst = 1'b1;
        for (int c = 0; c < 20; c++) step("rotate");
        // 20 grants from a fresh pointer across 4 always-requesting channels
        for (int i = 0; i < N; i++) chk("fair_count", 64'(grant_count[i]), 64'd5);

        in_valid = 4'b0100;
        data[2]  = -W'(5);
        for (int c = 0; c < 10; c++) step("only_ch2");

        rst = 1'b0; in_valid = '1;
        for (int i = 0; i < N; i++) data[i] = W'(100 + i);
        step("re_reset");
        rst = 1'b1;
        step("first_ch0");
        out_ready = 1'b0;
        for (int c = 0; c < 50; c++) step("stall");
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step("resume");

        channel_enable = 4'b1010;
        for (int c = 0; c < 10; c++) step("en_1010");

        channel_enable = '1; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) step("pre_midrst");
        rst = 1'b0;
        step("midrst");
        rst = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step("post_midrst");

        for (int c = 0; c < 2000; c++) begin
            rst            = ($urandom_range(63) != 0);
            channel_enable = N'($urandom);
            in_valid       = N'($urandom);
            out_ready      = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) data[i] = W'({$urandom(), $urandom()});
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cic_channel_arbiter.md
Name: cic_channel_arbiter

Overview:
Round-robin arbiter that merges the output streams of NumChannels independent cic_decimator instances (one per RF channel) onto a single tagged output stream. It feeds one shared downstream consumer (e.g. a single FIFO or packetizer). Each decimator keeps its own state; this block only shares the output path and back-pressures the decimators through their out_ready. Output is fully registered; sustained throughput is one sample per clock.

Parameters:
NumChannels, 4, number of requesting streams (2..16).
DataLengthBits, 36, width of each sample (matches decimator OutputLengthBits).
ChannelIdBits, 2, width of out_channel; must equal max(1, $clog2(NumChannels)).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-low reset (0 = reset asserted).
channel_enable  input  NumChannels  per-channel enable mask; disabled channels are never granted.
in  input  NumChannels*DataLengthBits  packed samples; channel i occupies bits [i*DataLengthBits +: DataLengthBits].
in_valid  input  NumChannels  per-channel valid.
in_ready  output  NumChannels  per-channel ready; wire to each decimator's out_ready.
out  output  DataLengthBits  merged sample (signed, passed through unmodified).
out_channel  output  ChannelIdBits  index of the channel that produced out.
out_valid  output  1  out/out_channel hold a sample.
out_ready  input  1  downstream accepts when out_valid && out_ready.

Behaviour:
- Reset (rst==0 at a clock edge): out_valid=0, out=0, out_channel=0, last_grant=NumChannels-1 (so channel 0 has first priority). in_ready=0 whenever rst==0, regardless of other inputs.
- Request vector req = in_valid & channel_enable.
- load = !out_valid || out_ready (output register empty or being drained this cycle).
- Grant (combinational): first i with req[i]=1, searching last_grant+1, last_grant+2, ... wrapping modulo NumChannels. At most one grant per cycle.
- in_ready[g] = load for granted channel g only; all other bits 0. No grant -> in_ready=0. in_ready never depends on in_valid of a non-granted channel.
- On edge with load && grant g: out<=in[g], out_channel<=g, out_valid<=1, last_grant<=g.
- On edge with load && no grant: out_valid<=0; out and out_channel retain last value.
- On edge with !load (out_valid && !out_ready): out, out_channel, out_valid, last_grant all hold; no input consumed.
- Latency: input handshake at edge N -> out_valid=1 with that sample after edge N (visible in cycle N+1).
- Simultaneous drain and refill: out_valid stays 1 with new data; no bubble.
- Fairness: with all channels continuously requesting and out_ready=1, grants rotate 0,1,2,3,0,...; any requesting enabled channel is granted within NumChannels accepted samples.
- channel_enable change takes effect on the next grant; a sample already in the output register is still delivered.
- Disabled or non-requesting channels are skipped without consuming a cycle.
- Reset mid-operation: pending output sample discarded, out_valid=0 on next cycle, pointer restored to reset value.
- No arithmetic on data; samples neither truncated nor sign-changed.

Test Plan:
- Hold rst=0 for 100 cycles with all in_valid=1, channel_enable=4'b1111, out_ready=1 -> out_valid=0, out=0, out_channel=0, in_ready=4'b0000 every cycle.
- Release reset; channel i continuously presents value 100+i, all valid, out_ready=1 -> out_valid=1 every cycle from the second cycle on; out_channel sequence 0,1,2,3,0,... and out=100+out_channel; each in_ready bit high exactly 1 cycle in 4.
- Only channel 2 valid (in=-5 sign-extended), 10 cycles -> out=-5, out_channel=2 every cycle after the first; in_ready=4'b0100 throughout.
- All valid, out_ready=0 for 50 cycles after first sample from channel 0 -> out holds 100, out_channel=0, out_valid=1, in_ready=0000; on out_ready=1 next accepted sample is channel 1.
- channel_enable=4'b1010, all valid -> out_channel alternates 1,3,1,3; in_ready[0] and in_ready[2] never high.
- Mid-stream (out_valid=1, out_ready=0) assert rst=0 for 1 cycle -> out_valid=0 next cycle; after release first grant is channel 0.
